// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - accumulates G_VEC_LEN signed partial sums, saturates and emits one result per vector.
// Optional ReLU after saturation: define NEURON_ACC_RELU_EN.
module neuron_accumulator #(
    parameter int G_IN_WIDTH  = 19,
    parameter int G_ACC_WIDTH = 32,
    parameter int G_OUT_WIDTH = 18,
    parameter int G_VEC_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_IN_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [G_OUT_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_ovf
);

    localparam int CNT_W = (G_VEC_LEN > 1) ? $clog2(G_VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(G_VEC_LEN - 1);

    generate
        if ((G_VEC_LEN < 1) || (G_ACC_WIDTH < G_IN_WIDTH + $clog2(G_VEC_LEN)) ||
            (G_ACC_WIDTH < G_OUT_WIDTH)) begin : g_bad_cfg
            $error("neuron_accumulator: G_ACC_WIDTH too narrow for G_IN_WIDTH/G_VEC_LEN/G_OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {S_ACC, S_OUT} t_state;

    t_state                         r_state;
    t_state                         w_next;
    logic                           r_rdy_en;
    logic signed [G_ACC_WIDTH-1:0]  r_acc;
    logic        [CNT_W-1:0]        r_cnt;
    logic        [G_OUT_WIDTH-1:0]  r_out_data;
    logic                           r_out_ovf;

    logic signed [G_IN_WIDTH-1:0]   w_in_s;
    logic signed [G_ACC_WIDTH-1:0]  w_in_ext;
    logic signed [G_ACC_WIDTH-1:0]  w_sum;
    logic signed [G_ACC_WIDTH-1:0]  w_max;
    logic signed [G_ACC_WIDTH-1:0]  w_min;
    logic        [G_OUT_WIDTH-1:0]  w_sat;
    logic        [G_OUT_WIDTH-1:0]  w_res;
    logic                           w_ovf;
    logic                           w_accept;
    logic                           w_last;

    assign w_in_s   = in_data;
    assign w_in_ext = G_ACC_WIDTH'(w_in_s);
    assign w_sum    = r_acc + w_in_ext;
    assign w_max    = {{(G_ACC_WIDTH-G_OUT_WIDTH+1){1'b0}}, {(G_OUT_WIDTH-1){1'b1}}};
    assign w_min    = {{(G_ACC_WIDTH-G_OUT_WIDTH+1){1'b1}}, {(G_OUT_WIDTH-1){1'b0}}};
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    always_comb begin
        w_sat = w_sum[G_OUT_WIDTH-1:0];
        w_ovf = 1'b0;
        if (w_sum > w_max) begin
            w_sat = {1'b0, {(G_OUT_WIDTH-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_sum < w_min) begin
            w_sat = {1'b1, {(G_OUT_WIDTH-1){1'b0}}};
            w_ovf = 1'b1;
        end
    end

`ifdef NEURON_ACC_RELU_EN
    // ReLU clamps negatives to zero; out_ovf keeps the pre-ReLU clip flag.
    assign w_res = w_sat[G_OUT_WIDTH-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_ACC: begin
                in_ready = r_rdy_en;
                if (w_accept && w_last) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_ACC;
                end
            end
            default: w_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_ACC;
            r_rdy_en   <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                if (w_last) begin
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_out_data <= w_res;
                    r_out_ovf  <= w_ovf;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_data = r_out_data;
    assign out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed and table-driven checks of neuron_accumulator with G_VEC_LEN=4.
module tb_neuron_accumulator;

    localparam int IW = 19;
    localparam int AW = 32;
    localparam int OW = 18;
    localparam int VL = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [IW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_ovf;

    int checks = 0;
    int errors = 0;

    neuron_accumulator #(
        .G_IN_WIDTH (IW),
        .G_ACC_WIDTH(AW),
        .G_OUT_WIDTH(OW),
        .G_VEC_LEN  (VL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     s[VL];
        longint exp_data;
        bit     exp_ovf;
    } t_vec;

    t_vec vecs[9];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the sample was accepted.
    task automatic push(input int v);
        int n;
        n = 0;
        in_data  = IW'(v);
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=in_ready_low required=in_ready_high");
        end
        @(negedge clk);
    endtask

    function automatic longint relu_adj(input longint d);
`ifdef NEURON_ACC_RELU_EN
        return (d < 0) ? 0 : d;
`else
        return d;
`endif
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint sum;
        longint exp_d;
        bit     exp_o;

        vecs[0] = '{s: '{1, 2, 3, 4},                         exp_data: 10,      exp_ovf: 0};
        vecs[1] = '{s: '{-5, -5, -5, -5},                     exp_data: -20,     exp_ovf: 0};
        vecs[2] = '{s: '{262143, 262143, 262143, 262143},     exp_data: 131071,  exp_ovf: 1};
        vecs[3] = '{s: '{-262144, -262144, -262144, -262144}, exp_data: -131072, exp_ovf: 1};
        vecs[4] = '{s: '{131071, 0, 0, 0},                    exp_data: 131071,  exp_ovf: 0};
        vecs[5] = '{s: '{131071, 1, 0, 0},                    exp_data: 131071,  exp_ovf: 1};
        vecs[6] = '{s: '{-131072, 0, 0, 0},                   exp_data: -131072, exp_ovf: 0};
        vecs[7] = '{s: '{-131072, -1, 0, 0},                  exp_data: -131072, exp_ovf: 1};
        vecs[8] = '{s: '{100, -50, 7, -57},                   exp_data: 0,       exp_ovf: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_ovf", out_ovf, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < VL; j++) push(vecs[i].s[j]);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_out_data", i), out_data, relu_adj(vecs[i].exp_data));
            chk($sformatf("vec%0d_out_ovf", i), out_ovf, vecs[i].exp_ovf);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_drop", i), out_valid, 0);
            chk($sformatf("vec%0d_ready_back", i), in_ready, 1);
        end

        // Backpressure in OUT with a pending sample
        out_ready = 1'b0;
        push(1); push(2); push(3); push(4);
        in_data  = IW'(7);
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        push(7); push(1); push(1); push(1);
        in_valid = 1'b0;
        chk("post_stall_valid", out_valid, 1);
        chk("post_stall_data", out_data, 10);
        @(negedge clk);

        // Random gaps and output backpressure against a reference sum
        out_ready = 1'b0;
        for (int v = 0; v < 100; v++) begin
            sum = 0;
            for (int j = 0; j < VL; j++) begin
                int x;
                if ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 524287)) - 262144;
                else x = int'($urandom_range(0, 131071)) - 65536;
                sum += x;
                push(x);
            end
            in_valid = 1'b0;
            exp_o = 1'b0;
            exp_d = sum;
            if (sum > 131071) begin exp_d = 131071; exp_o = 1'b1; end
            else if (sum < -131072) begin exp_d = -131072; exp_o = 1'b1; end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk($sformatf("rand%0d_valid", v), out_valid, 1);
            chk($sformatf("rand%0d_data", v), out_data, relu_adj(exp_d));
            chk($sformatf("rand%0d_ovf", v), out_ovf, exp_o);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        // Reset mid-vector
        out_ready = 1'b1;
        push(1); push(2); push(3); push(4);
        in_valid = 1'b0;
        chk("pre_rst_data", out_data, 10);
        @(negedge clk);
        push(1); push(1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midvec_rst_out_data", out_data, 0);
        chk("midvec_rst_out_valid", out_valid, 0);
        chk("midvec_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        push(1); push(1); push(1); push(1);
        in_valid = 1'b0;
        chk("after_rst_valid", out_valid, 1);
        chk("after_rst_data", out_data, 4);
        chk("after_rst_ovf", out_ovf, 0);
        @(negedge clk);

        // Reset while holding a result in OUT
        out_ready = 1'b0;
        push(262143); push(262143); push(0); push(0);
        in_valid = 1'b0;
        chk("midout_valid", out_valid, 1);
        chk("midout_ovf", out_ovf, 1);
        rst = 1'b1;
        #1;
        chk("midout_rst_valid", out_valid, 0);
        chk("midout_rst_data", out_data, 0);
        chk("midout_rst_ovf", out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midout_no_output", out_valid, 0);
        end
        out_ready = 1'b1;
        push(-1); push(-2); push(-3); push(-4);
        in_valid = 1'b0;
        chk("final_valid", out_valid, 1);
        chk("final_data", out_data, relu_adj(-10));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
